alu_muldiv: RTL and testbench

- Parametrised successor to the single-cycle integer ALU: XLEN-generic, with a valid/ready handshake and a registered result.
- Adds the RV32M/RV64M multiply/divide ops, executed by an iterative radix-2 engine.
- Sits in the execute stage between operand select and writeback.
- Single-cycle ops complete in 1 cycle; MUL*/DIV*/REM* ops stall the pipe via in_ready.

---
 rtl/alu_muldiv.sv | 218 +++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// Execute-stage integer ALU with a registered result. The M-extension multiply
// and divide ops run on a shared iterative radix-2 engine (one bit per cycle).
module alu_muldiv #(
    parameter int XLEN         = 32,
    parameter int ALU_OP_WIDTH = 5,
    parameter int SHAMT_WIDTH  = $clog2(XLEN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         a,
    input  logic [XLEN-1:0]         b,
    input  logic [ALU_OP_WIDTH-1:0] alu_op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out,
    output logic                    busy,
    output logic [1:0]              dbg_state
);
    // Handshake: an op transfers on a rising edge where in_valid && in_ready && !flush,
    // a result transfers where out_valid && out_ready; neither side may depend on the
    // other's valid combinationally except in_ready following out_ready in DONE.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [ALU_OP_WIDTH-1:0] OP_ADD    = ALU_OP_WIDTH'(0);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SLL    = ALU_OP_WIDTH'(1);
    localparam logic [ALU_OP_WIDTH-1:0] OP_XOR    = ALU_OP_WIDTH'(2);
    localparam logic [ALU_OP_WIDTH-1:0] OP_OR     = ALU_OP_WIDTH'(3);
    localparam logic [ALU_OP_WIDTH-1:0] OP_AND    = ALU_OP_WIDTH'(4);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SRL    = ALU_OP_WIDTH'(5);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SEQ    = ALU_OP_WIDTH'(6);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SNE    = ALU_OP_WIDTH'(7);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SUB    = ALU_OP_WIDTH'(8);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SRA    = ALU_OP_WIDTH'(9);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SLT    = ALU_OP_WIDTH'(10);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SGE    = ALU_OP_WIDTH'(11);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SLTU   = ALU_OP_WIDTH'(12);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SGEU   = ALU_OP_WIDTH'(13);
    localparam logic [ALU_OP_WIDTH-1:0] OP_MUL    = ALU_OP_WIDTH'(16);
    localparam logic [ALU_OP_WIDTH-1:0] OP_MULH   = ALU_OP_WIDTH'(17);
    localparam logic [ALU_OP_WIDTH-1:0] OP_MULHSU = ALU_OP_WIDTH'(18);
    localparam logic [ALU_OP_WIDTH-1:0] OP_MULHU  = ALU_OP_WIDTH'(19);
    localparam logic [ALU_OP_WIDTH-1:0] OP_DIV    = ALU_OP_WIDTH'(20);
    localparam logic [ALU_OP_WIDTH-1:0] OP_DIVU   = ALU_OP_WIDTH'(21);
    localparam logic [ALU_OP_WIDTH-1:0] OP_REM    = ALU_OP_WIDTH'(22);
    localparam logic [ALU_OP_WIDTH-1:0] OP_REMU   = ALU_OP_WIDTH'(23);

    logic [1:0]              state_q, state_d;
    logic [XLEN-1:0]         out_q, out_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [ALU_OP_WIDTH-1:0] op_q, op_d;
    logic [XLEN-1:0]         hi_q, hi_d, lo_q, lo_d, md_q, md_d;
    logic                    neg_q, neg_d;

    logic [SHAMT_WIDTH-1:0] shamt;
    logic                   slt, sltu;
    logic [XLEN-1:0]        alu_res;

    assign shamt = b[SHAMT_WIDTH-1:0];
    assign slt   = $signed(a) < $signed(b);
    assign sltu  = a < b;

    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_ADD:  alu_res = a + b;
            OP_SLL:  alu_res = a << shamt;
            OP_XOR:  alu_res = a ^ b;
            OP_OR:   alu_res = a | b;
            OP_AND:  alu_res = a & b;
            OP_SRL:  alu_res = a >> shamt;
            OP_SEQ:  alu_res = XLEN'(a == b);
            OP_SNE:  alu_res = XLEN'(a != b);
            OP_SUB:  alu_res = a - b;
            OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
            OP_SLT:  alu_res = XLEN'(slt);
            OP_SGE:  alu_res = XLEN'(!slt);
            OP_SLTU: alu_res = XLEN'(sltu);
            OP_SGEU: alu_res = XLEN'(!sltu);
            default: alu_res = '0;
        endcase
    end

    logic            is_mul, is_div, is_rem, sgn_a, sgn_b, b_zero, div_ovf, fast;
    logic [XLEN-1:0] mag_a, mag_b, fast_res;

    assign is_mul  = (alu_op >= OP_MUL) && (alu_op <= OP_MULHU);
    assign is_div  = (alu_op >= OP_DIV) && (alu_op <= OP_REMU);
    assign is_rem  = (alu_op == OP_REM) || (alu_op == OP_REMU);
    assign sgn_a   = a[XLEN-1] && ((alu_op == OP_MUL) || (alu_op == OP_MULH) ||
                     (alu_op == OP_MULHSU) || (alu_op == OP_DIV) || (alu_op == OP_REM));
    assign sgn_b   = b[XLEN-1] && ((alu_op == OP_MUL) || (alu_op == OP_MULH) ||
                     (alu_op == OP_DIV) || (alu_op == OP_REM));
    assign mag_a   = sgn_a ? -a : a;
    assign mag_b   = sgn_b ? -b : b;
    assign b_zero  = (b == '0);
    assign div_ovf = ((alu_op == OP_DIV) || (alu_op == OP_REM)) && (a == MIN_NEG) && (b == '1);
    assign fast    = is_div && (b_zero || div_ovf);

    always_comb begin
        if (b_zero) fast_res = is_rem ? a : '1;
        else        fast_res = is_rem ? '0 : a;
    end

    // Engine: {hi,lo} is the product accumulator (mul) or remainder/quotient pair (div).
    logic              mul_op_q;
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic [XLEN-1:0]   step_hi, step_lo, quo_fix, rem_fix, final_res;
    logic [2*XLEN-1:0] prod, prod_fix;

    assign mul_op_q = (op_q >= OP_MUL) && (op_q <= OP_MULHU);
    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, md_q} : '0);
    assign div_sh   = {hi_q, lo_q[XLEN-1]};
    assign div_diff = div_sh - {1'b0, md_q};

    always_comb begin
        if (mul_op_q) begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end else if (!div_diff[XLEN]) begin
            step_hi = div_diff[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], 1'b1};
        end else begin
            step_hi = div_sh[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], 1'b0};
        end
    end

    assign prod     = {step_hi, step_lo};
    assign prod_fix = neg_q ? -prod : prod;
    assign quo_fix  = neg_q ? -step_lo : step_lo;
    assign rem_fix  = neg_q ? -step_hi : step_hi;

    always_comb begin
        case (op_q)
            OP_MUL:                        final_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod_fix[2*XLEN-1:XLEN];
            OP_REM, OP_REMU:               final_res = rem_fix;
            default:                       final_res = quo_fix;
        endcase
    end

    logic accept;
    assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        md_d    = md_q;
        neg_d   = neg_q;
        if (flush) begin
            state_d = S_IDLE;
        end else if (accept) begin
            op_d = alu_op;
            if ((is_mul || is_div) && !fast) begin
                state_d = S_BUSY;
                cnt_d   = CW'(XLEN);
                hi_d    = '0;
                lo_d    = is_mul ? mag_b : mag_a;
                md_d    = is_mul ? mag_a : mag_b;
                neg_d   = is_rem ? sgn_a : (sgn_a ^ sgn_b);
            end else begin
                state_d = S_DONE;
                out_d   = fast ? fast_res : alu_res;
            end
        end else if (state_q == S_BUSY) begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                out_d   = final_res;
                state_d = S_DONE;
            end
        end else if ((state_q == S_DONE) && out_ready) begin
            state_d = S_IDLE;
        end else if (state_q != S_DONE) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            md_q    <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            md_q    <= md_d;
            neg_q   <= neg_d;
        end
    end

    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_BUSY);
    assign out       = out_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: directed cases with known answers, a random phase checked
// against a behavioural reference, and a result scoreboard fed at accept time.
module tb_alu_muldiv;
    localparam int W = 32;

    localparam logic [4:0] ADD  = 5'd0;
    localparam logic [4:0] XOR  = 5'd2;
    localparam logic [4:0] AND  = 5'd4;
    localparam logic [4:0] SUB  = 5'd8;
    localparam logic [4:0] SRA  = 5'd9;
    localparam logic [4:0] SLT  = 5'd10;
    localparam logic [4:0] SLTU = 5'd12;
    localparam logic [4:0] MUL  = 5'd16;
    localparam logic [4:0] MULH = 5'd17;
    localparam logic [4:0] MULHU = 5'd19;
    localparam logic [4:0] DIV  = 5'd20;
    localparam logic [4:0] DIVU = 5'd21;
    localparam logic [4:0] REM  = 5'd22;

    logic         clk, rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [W-1:0] a, b, out;
    logic [4:0]   alu_op;
    logic [1:0]   dbg_state;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    logic [W-1:0] exp_q[$];
    string        tag_q[$];

    alu_muldiv #(.XLEN(W), .ALU_OP_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alu_op(alu_op), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .busy(busy), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] ref_model(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [63:0] sx, sy;
        logic [63:0] ux, uy, p;
        int ix, iy;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'b0, x};
        uy = {32'b0, y};
        ix = x;
        iy = y;
        case (op)
            5'd0:  return x + y;
            5'd1:  return x << y[4:0];
            5'd2:  return x ^ y;
            5'd3:  return x | y;
            5'd4:  return x & y;
            5'd5:  return x >> y[4:0];
            5'd6:  return {31'b0, x == y};
            5'd7:  return {31'b0, x != y};
            5'd8:  return x - y;
            5'd9:  return $unsigned($signed(x) >>> y[4:0]);
            5'd10: return {31'b0, ix < iy};
            5'd11: return {31'b0, ix >= iy};
            5'd12: return {31'b0, x < y};
            5'd13: return {31'b0, x >= y};
            5'd16: begin p = sx * sy; return p[31:0]; end
            5'd17: begin p = sx * sy; return p[63:32]; end
            5'd18: begin p = sx * $signed(uy); return p[63:32]; end
            5'd19: begin p = ux * uy; return p[63:32]; end
            5'd20: begin
                if (y == 0) return '1;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                return 32'(ix / iy);
            end
            5'd21: return (y == 0) ? '1 : x / y;
            5'd22: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return '0;
                return 32'(ix % iy);
            end
            5'd23: return (y == 0) ? x : x % y;
            default: return '0;
        endcase
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // driver tasks: called at posedge+1, return at posedge+1 after the accept edge
    task automatic issue(input logic [4:0] op, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic [W-1:0] exp, input bit track, input string tag, output int acc);
        bit ok;
        ok = 1'b0;
        acc = 0;
        in_valid = 1'b1;
        alu_op = op;
        a = xa;
        b = xb;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            if (track) begin
                exp_q.push_back(exp);
                tag_q.push_back(tag);
            end
            @(posedge clk);
            #1;
            acc = cyc;
        end else begin
            check({tag, "_accept_timeout"}, 32'(ok), 32'd1);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int acc, output int lat, output int bcnt);
        lat = 0;
        bcnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (out_valid) begin
                lat = cyc - acc + 1;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [4:0] op, input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic [W-1:0] exp, input int exp_lat, input int exp_busy, input string tag);
        int acc, lat, bcnt;
        issue(op, xa, xb, exp, 1'b1, tag, acc);
        wait_valid(acc, lat, bcnt);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(bcnt), 32'(exp_busy));
        @(posedge clk);
        #1;
    endtask

    // scoreboard
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
            else check(tag_q.pop_front(), out, exp_q.pop_front());
        end
    end

    initial begin
        int acc, acc2, lat, bcnt, seen, c0;
        logic [4:0] rop;
        logic [W-1:0] ra, rb;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; alu_op = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out", out, 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_state", 32'(dbg_state), 32'd0);
        @(posedge clk);
        #1;

        issue(ADD, 32'd5, 32'd7, 32'd12, 1'b1, "add", acc);
        fork
            issue(SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1, "sub", acc2);
            begin
                @(negedge clk);
                check("add_valid_lat1", 32'(out_valid), 32'd1);
                check("add_in_ready", 32'(in_ready), 32'd1);
            end
        join
        check("b2b_accept_cycle", 32'(acc2), 32'(acc + 1));
        @(posedge clk);
        #1;

        run_op(SRA,  32'h8000_0000, 32'h21,        32'hC000_0000, 1, 0, "sra");
        run_op(SLTU, 32'h1,         32'hFFFF_FFFF, 32'h1,         1, 0, "sltu");
        run_op(SLT,  32'h1,         32'hFFFF_FFFF, 32'h0,         1, 0, "slt");
        run_op(MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         33, 32, "mulh");
        run_op(MULHU,32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 32, "mulhu");
        run_op(MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         33, 32, "mul");
        run_op(DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 32, "div_neg");
        run_op(REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 32, "rem_neg");
        run_op(DIVU, 32'd7,         32'd0,         32'hFFFF_FFFF, 1, 0, "divu_by0");
        run_op(REM,  32'd9,         32'd0,         32'd9,         1, 0, "rem_by0");
        run_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, "div_ovf");
        run_op(REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1, 0, "rem_ovf");

        // back-pressure then simultaneous consume + accept
        out_ready = 1'b0;
        issue(XOR, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'hAAAA_AAAA, 1'b1, "bp_xor", acc);
        wait_valid(acc, lat, bcnt);
        check("bp_latency", 32'(lat), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_out_stable", out, 32'hAAAA_AAAA);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_out_valid_held", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        c0 = cyc;
        issue(AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b1, "bp_and", acc);
        check("bp_same_edge_accept", 32'(acc), 32'(c0 + 1));
        wait_valid(acc, lat, bcnt);
        check("bp_and_latency", 32'(lat), 32'd1);
        @(posedge clk);
        #1;

        // flush on cycle 10 of a DIVU, with an in_valid that must be ignored
        issue(DIVU, 32'd100, 32'd7, 32'd0, 1'b0, "flushed_divu", acc);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        in_valid = 1'b1; alu_op = ADD; a = 32'd1; b = 32'd1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        check("flush_state", 32'(dbg_state), 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush_no_valid", 32'(seen), 32'd0);
        @(posedge clk);
        #1;
        run_op(ADD, 32'd5, 32'd7, 32'd12, 1, 0, "post_flush_add");

        // reset on cycle 10 of a DIVU
        issue(DIVU, 32'd1000, 32'd3, 32'd0, 1'b0, "reset_divu", acc);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out", out, 32'h0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // random ops against the reference model
        for (int n = 0; n < 60; n++) begin
            rop = 5'($urandom_range(0, 31));
            ra = pick();
            rb = pick();
            issue(rop, ra, rb, ref_model(rop, ra, rb), 1'b1, $sformatf("rand_op%0d", rop), acc);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
